// File: rtl/fruit_pkg.sv
// fruit_pkg: types and screen constants shared by the fruit spawner and the
// fruit motion stage.
//   spawner_state_t : launch FSM states
//   fruit_kind_t    : 2-bit fruit type carried with every launch
//   X_MAX / Y_MAX   : last visible pixel column / row
//   LFSR_TAPS       : Galois feedback mask for x^16+x^14+x^13+x^11
package fruit_pkg;

  localparam int unsigned X_MAX = 639;
  localparam int unsigned Y_MAX = 479;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ARMED = 2'd2,
    SPAWN = 2'd3
  } spawner_state_t;

  typedef logic [1:0] fruit_kind_t;

endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR, one step per enabled clock edge.
//   frame_clk : clock
//   Reset     : asynchronous active-high reset, loads SEED
//   enable    : advance the sequence on this edge
//   value     : current LFSR state
module lfsr16
  import fruit_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              frame_clk,
  input  logic              Reset,
  input  logic              enable,
  output logic [LFSR_W-1:0] value
);

  // Shift right; when the bit leaving the bottom is 1, fold in the taps.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      value <= SEED;
    end else if (enable) begin
      value <= value[0] ? ((value >> 1) ^ LFSR_TAPS) : (value >> 1);
    end
  end

endmodule

// File: rtl/fruit_spawner.sv
// fruit_spawner: decides when a new fruit is launched and with what initial
// state. One frame_clk cycle is one video frame.
//   frame_clk   : frame-rate clock
//   Reset       : asynchronous active-high reset
//   game_run    : launching enabled while high (overrides everything)
//   slot_free   : downstream fruit slot can accept a new fruit
//   fruits_cut  : cut count, shortens the launch interval
//   new_fruit   : one-cycle launch strobe
//   spawn_x     : start X position
//   spawn_x_vel : X velocity, two's complement
//   spawn_y_vel : Y velocity, two's complement, negative is upward
//   spawn_kind  : fruit type
//   spawn_count : launches since reset, saturating at 255
module fruit_spawner
  import fruit_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1,
  parameter int unsigned       BASE_INTERVAL = 90,
  parameter int unsigned       MIN_INTERVAL  = 20,
  parameter int unsigned       X_MIN         = 64,
  parameter int unsigned       X_MID         = 320,
  parameter int unsigned       VY_BASE       = 8
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               game_run,
  input  logic               slot_free,
  input  logic [COUNT_W-1:0] fruits_cut,
  output logic               new_fruit,
  output logic [COORD_W-1:0] spawn_x,
  output logic [COORD_W-1:0] spawn_x_vel,
  output logic [COORD_W-1:0] spawn_y_vel,
  output fruit_kind_t        spawn_kind,
  output logic [COUNT_W-1:0] spawn_count
);

  localparam int unsigned DIFF_W = 9;
  localparam int unsigned CNT_W  = $clog2(BASE_INTERVAL + 1);

  spawner_state_t     state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [LFSR_W-1:0]  rnd;

  logic [DIFF_W-1:0]  diff_c;
  logic [CNT_W-1:0]   interval_c;
  logic [COORD_W-1:0] x_c;
  logic [COORD_W-1:0] mag_c;
  logic [COORD_W-1:0] x_vel_c;
  logic [COORD_W-1:0] y_vel_c;

  // Free-running random source; steps every frame regardless of state.
  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .enable    (1'b1),
    .value     (rnd)
  );

  // Launch interval shrinks by two frames per cut, floored at MIN_INTERVAL.
  always_comb begin
    diff_c     = {fruits_cut, 1'b0};
    interval_c = CNT_W'(MIN_INTERVAL);
    if (diff_c < DIFF_W'(BASE_INTERVAL - MIN_INTERVAL)) begin
      interval_c = CNT_W'(DIFF_W'(BASE_INTERVAL) - diff_c);
    end
  end

  // Launch fields from the current LFSR value; X velocity points toward centre.
  always_comb begin
    x_c     = COORD_W'(X_MIN) + COORD_W'(rnd[8:0]);
    mag_c   = COORD_W'(rnd[10:9]) + COORD_W'(1);
    x_vel_c = (x_c < COORD_W'(X_MID)) ? mag_c : (COORD_W'(0) - mag_c);
    y_vel_c = COORD_W'(0) - (COORD_W'(VY_BASE) + COORD_W'(rnd[13:11]));
  end

  // Launch FSM; game_run low sends every state back to IDLE without a strobe.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      new_fruit   <= 1'b0;
      spawn_x     <= '0;
      spawn_x_vel <= '0;
      spawn_y_vel <= '0;
      spawn_kind  <= '0;
      spawn_count <= '0;
    end else begin
      new_fruit <= 1'b0;
      if (!game_run) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            wait_cnt <= interval_c;
            state    <= WAIT;
          end
          WAIT: begin
            wait_cnt <= wait_cnt - CNT_W'(1);
            if (wait_cnt == CNT_W'(1)) begin
              state <= ARMED;
            end
          end
          ARMED: begin
            if (slot_free) begin
              spawn_x     <= x_c;
              spawn_x_vel <= x_vel_c;
              spawn_y_vel <= y_vel_c;
              spawn_kind  <= fruit_kind_t'(rnd[15:14]);
              new_fruit   <= 1'b1;
              if (spawn_count != '1) begin
                spawn_count <= spawn_count + COUNT_W'(1);
              end
              state <= SPAWN;
            end
          end
          SPAWN: begin
            wait_cnt <= interval_c;
            state    <= WAIT;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fruit_spawner.sv
// tb_fruit_spawner: scoreboard bench for fruit_spawner. A launch-time model
// (interval arithmetic plus a reference LFSR) pushes expected launches; a
// monitor pops them when the DUT strobes and checks held fields every frame.
module tb_fruit_spawner;

  logic       frame_clk;
  logic       Reset;
  logic       game_run;
  logic       slot_free;
  logic [7:0] fruits_cut;
  logic       new_fruit;
  logic [9:0] spawn_x;
  logic [9:0] spawn_x_vel;
  logic [9:0] spawn_y_vel;
  logic [1:0] spawn_kind;
  logic [7:0] spawn_count;

  fruit_spawner dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .game_run    (game_run),
    .slot_free   (slot_free),
    .fruits_cut  (fruits_cut),
    .new_fruit   (new_fruit),
    .spawn_x     (spawn_x),
    .spawn_x_vel (spawn_x_vel),
    .spawn_y_vel (spawn_y_vel),
    .spawn_kind  (spawn_kind),
    .spawn_count (spawn_count)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int         n;
    logic [9:0] x;
    logic [9:0] xv;
    logic [9:0] yv;
    logic [1:0] kind;
    logic [7:0] cnt;
  } launch_t;

  launch_t exp_q[$];
  int      strobe_edges[$];
  int      strobe_counts[$];
  int      vectors;
  int      miscompares;
  int      edge_cnt;

  // Reference model state
  logic [15:0] m_lfsr;
  bit          m_run;
  bit          m_reload;
  int          m_elig;
  int          m_cnt;
  launch_t     m_held;

  function automatic int interval_of(input int fc);
    int d;
    d = 2 * fc;
    return (d >= 90 - 20) ? 20 : 90 - d;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] r);
    return r[0] ? ((r >> 1) ^ 16'hB400) : (r >> 1);
  endfunction

  function automatic launch_t make_launch(input int n, input logic [15:0] r, input int cnt);
    launch_t l;
    int xi, mag;
    xi     = 64 + int'(r[8:0]);
    mag    = int'(r[10:9]) + 1;
    l.n    = n;
    l.x    = 10'(xi);
    l.xv   = (xi < 320) ? 10'(mag) : 10'(-mag);
    l.yv   = 10'(-(8 + int'(r[13:11])));
    l.kind = r[15:14];
    l.cnt  = 8'(cnt);
    return l;
  endfunction

  // Model: a run starts on the first game_run edge, the next launch may occur
  // interval+1 edges after each counter load, and the load after a launch
  // happens on the edge following it.
  initial begin
    edge_cnt = 0;
    forever begin
      @(posedge frame_clk or posedge Reset);
      if (Reset) begin
        m_lfsr   = 16'hACE1;
        m_run    = 0;
        m_reload = 0;
        m_cnt    = 0;
        m_held   = '{n: 0, x: '0, xv: '0, yv: '0, kind: '0, cnt: '0};
        exp_q.delete();
      end else begin
        edge_cnt++;
        if (!game_run) begin
          m_run    = 0;
          m_reload = 0;
        end else if (!m_run) begin
          m_run  = 1;
          m_elig = edge_cnt + interval_of(int'(fruits_cut)) + 1;
        end else if (m_reload) begin
          m_reload = 0;
          m_elig   = edge_cnt + interval_of(int'(fruits_cut)) + 1;
        end else if (edge_cnt >= m_elig && slot_free) begin
          if (m_cnt < 255) m_cnt++;
          m_held = make_launch(edge_cnt, m_lfsr, m_cnt);
          exp_q.push_back(m_held);
          m_reload = 1;
        end
        m_lfsr = lfsr_next(m_lfsr);
      end
    end
  end

  // Monitor: strobe timing against the queue, ranges at each launch, and
  // all fields against the last expected launch every frame.
  initial begin
    launch_t e;
    bit      exp_nf;
    bit      prev_nf;
    int      xi, xv, yv;
    prev_nf = 0;
    forever begin
      @(negedge frame_clk);
      if (Reset) begin
        prev_nf = 0;
        continue;
      end
      while (exp_q.size() > 0 && exp_q[0].n < edge_cnt) begin
        vectors++; miscompares++;
        $display("FAIL strobe_missing: no new_fruit at edge %0d", exp_q[0].n);
        void'(exp_q.pop_front());
      end
      exp_nf = 0;
      if (exp_q.size() > 0 && exp_q[0].n == edge_cnt) begin
        e = exp_q.pop_front();
        exp_nf = 1;
      end
      vectors++;
      if (new_fruit !== exp_nf || (prev_nf && new_fruit)) begin
        miscompares++;
        $display("FAIL strobe edge %0d: new_fruit=%b prev=%b, required %b", edge_cnt, new_fruit, prev_nf, exp_nf);
      end
      prev_nf = new_fruit;
      if (new_fruit) begin
        strobe_edges.push_back(edge_cnt);
        strobe_counts.push_back(int'(spawn_count));
        xi = int'(spawn_x);
        xv = int'($signed(spawn_x_vel));
        yv = int'(spawn_y_vel);
        vectors++;
        if (xi < 64 || xi > 575 || ((xv > 0) != (xi < 320)) || xv == 0 || xv > 4 || xv < -4
            || yv < 10'h3F1 || yv > 10'h3F8) begin
          miscompares++;
          $display("FAIL field_range edge %0d: x=%0d xv=%0d yv=%h", edge_cnt, xi, xv, spawn_y_vel);
        end
      end
      vectors++;
      if (spawn_x !== m_held.x || spawn_x_vel !== m_held.xv || spawn_y_vel !== m_held.yv
          || spawn_kind !== m_held.kind || spawn_count !== m_held.cnt) begin
        miscompares++;
        $display("FAIL fields edge %0d: got x=%0d xv=%h yv=%h kind=%0d cnt=%0d, required x=%0d xv=%h yv=%h kind=%0d cnt=%0d",
                 edge_cnt, spawn_x, spawn_x_vel, spawn_y_vel, spawn_kind, spawn_count,
                 m_held.x, m_held.xv, m_held.yv, m_held.kind, m_held.cnt);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  task automatic wait_strobes(input string name, input int k, input int budget);
    int c;
    c = 0;
    while (strobe_edges.size() < k && c < budget) begin
      @(negedge frame_clk);
      #1;
      c++;
    end
    if (strobe_edges.size() < k) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: %0d strobes seen, required %0d", name, strobe_edges.size(), k);
    end
  endtask

  task automatic check_gap(input string name, input int i, input int start, input int want);
    int base;
    vectors++;
    if (i >= strobe_edges.size()) begin
      miscompares++;
      $display("FAIL %s: strobe %0d absent, required gap %0d", name, i, want);
    end else begin
      base = (i == 0) ? start : strobe_edges[i-1];
      if (strobe_edges[i] - base != want) begin
        miscompares++;
        $display("FAIL %s: gap %0d, required %0d", name, strobe_edges[i] - base, want);
      end
    end
  endtask

  task automatic check_cnt(input string name, input int i, input int want);
    vectors++;
    if (i >= strobe_counts.size() || strobe_counts[i] != want) begin
      miscompares++;
      $display("FAIL %s: spawn_count %0d, required %0d", name,
               (i < strobe_counts.size()) ? strobe_counts[i] : -1, want);
    end
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if ({new_fruit, spawn_x, spawn_x_vel, spawn_y_vel, spawn_kind, spawn_count} !== '0) begin
      miscompares++;
      $display("FAIL %s: nf=%b x=%0d xv=%h yv=%h kind=%0d cnt=%0d, required all 0", name,
               new_fruit, spawn_x, spawn_x_vel, spawn_y_vel, spawn_kind, spawn_count);
    end
  endtask

  task automatic restart(input int fc, input bit sf, output int start);
    game_run = 0;
    cyc(3);
    strobe_edges.delete();
    strobe_counts.delete();
    fruits_cut = 8'(fc);
    slot_free  = sf;
    game_run   = 1;
    start      = edge_cnt + 1;
  endtask

  initial begin
    int start, n;
    vectors = 0; miscompares = 0;
    Reset = 1; game_run = 0; slot_free = 0; fruits_cut = '0;
    cyc(3);
    check_zero("reset_values");
    Reset = 0;

    // Base interval: 91 to first strobe, then every 92, counts 1,2,3
    restart(0, 1, start);
    wait_strobes("base", 3, 400);
    check_gap("base_first", 0, start, 91);
    check_gap("base_period1", 1, start, 92);
    check_gap("base_period2", 2, start, 92);
    check_cnt("base_cnt1", 0, 1);
    check_cnt("base_cnt2", 1, 2);
    check_cnt("base_cnt3", 2, 3);

    // Difficulty: fruits_cut changes mid-WAIT take effect at the next load
    restart(10, 1, start);
    wait_strobes("diff", 1, 200);
    check_gap("diff_first", 0, start, 71);
    cyc(10);
    fruits_cut = 8'd40;
    wait_strobes("diff", 3, 300);
    check_gap("diff_period72", 1, start, 72);
    check_gap("diff_period22", 2, start, 22);

    // Backpressure: slot_free low for 50 frames after WAIT expires
    restart(40, 0, start);
    cyc(20 + 50);
    vectors++;
    if (strobe_edges.size() != 0) begin
      miscompares++;
      $display("FAIL backpressure_hold: %0d strobes, required 0", strobe_edges.size());
    end
    slot_free = 1;
    n = edge_cnt + 1;
    wait_strobes("backpressure", 1, 10);
    check_gap("backpressure_release", 0, n, 0);

    // Abort: game_run drops on the edge ARMED would launch
    restart(40, 0, start);
    cyc(21);
    game_run  = 0;
    slot_free = 1;
    cyc(4);
    vectors++;
    if (strobe_edges.size() != 0) begin
      miscompares++;
      $display("FAIL abort_strobe: %0d strobes, required 0", strobe_edges.size());
    end
    game_run = 1;
    start = edge_cnt + 1;
    wait_strobes("abort_restart", 1, 100);
    check_gap("abort_from_idle", 0, start, 21);

    // Reset mid-WAIT: outputs clear asynchronously, LFSR restarts from seed
    wait_strobes("pre_reset", 3, 100);
    cyc(5);
    #2 Reset = 1;
    #1 check_zero("reset_async");
    strobe_edges.delete();
    strobe_counts.delete();
    @(negedge frame_clk);
    Reset = 0;
    start = edge_cnt + 1;
    wait_strobes("post_reset", 1, 100);
    check_gap("post_reset_first", 0, start, 21);
    check_cnt("post_reset_cnt", 0, 1);

    // Random fields: 2000 launches with random slot_free and difficulty
    strobe_edges.delete();
    for (int i = 0; i < 70000 && strobe_edges.size() < 2000; i++) begin
      @(negedge frame_clk);
      slot_free  = ($urandom_range(0, 7) != 0);
      fruits_cut = 8'($urandom_range(35, 255));
    end
    vectors++;
    if (strobe_edges.size() < 2000) begin
      miscompares++;
      $display("FAIL random_launches: %0d launches, required 2000", strobe_edges.size());
    end
    cyc(2);
    vectors++;
    if (spawn_count !== 8'd255) begin
      miscompares++;
      $display("FAIL saturation: spawn_count %0d, required 255", spawn_count);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
